note_player: RTL and testbench



---
 rtl/music_pkg.sv | 16 +
 rtl/note_player_if.sv | 26 ++
 rtl/dffr.sv | 17 +
 rtl/dffre.sv | 18 +
 rtl/frequency_rom.sv | 46 ++++
 rtl/note_player.sv | 97 +++++++++
 tb/tb_note_player.sv | 218 +++++++++++++++++++++
 7 files changed

// File: rtl/music_pkg.sv
// Shared constants and state encoding for the music-player datapath.
package music_pkg;

    localparam int unsigned NOTE_WIDTH = 6;
    localparam int unsigned DUR_WIDTH  = 6;
    localparam int unsigned STEP_WIDTH = 20;

    localparam int unsigned REST_NOTE  = 0;

    typedef enum logic [2:0] {
        NP_IDLE     = 3'b001,
        NP_PLAYING  = 3'b010,
        NP_FINISHED = 3'b100
    } np_state_t;

endpackage

// File: rtl/note_player_if.sv
// Note handshake between the song sequencer (master) and the note player (slave).
interface note_player_if #(
    parameter int unsigned NOTE_WIDTH = music_pkg::NOTE_WIDTH,
    parameter int unsigned DUR_WIDTH  = music_pkg::DUR_WIDTH
) ();

    logic                  new_note;
    logic [NOTE_WIDTH-1:0] note;
    logic [DUR_WIDTH-1:0]  duration;
    logic                  note_done;

    modport master (
        output new_note,
        output note,
        output duration,
        input  note_done
    );

    modport slave (
        input  new_note,
        input  note,
        input  duration,
        output note_done
    );

endinterface

// File: rtl/dffr.sv
// Flop with synchronous active-high reset.
module dffr #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) q <= RST_VAL;
        else       q <= d;
    end

endmodule

// File: rtl/dffre.sv
// Flop with synchronous active-high reset and load enable.
module dffre #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset)   q <= RST_VAL;
        else if (en) q <= d;
    end

endmodule

// File: rtl/frequency_rom.sv
// 64-entry synchronous-read phase-step ROM (20-bit phase accumulator at 48 kHz); entry 0 is silence.
module frequency_rom #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    // Top octave (notes 63 down to 52) is tabulated; lower octaves halve per 12 notes.
    function automatic logic [DATA_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] a);
        int unsigned             t;
        int unsigned             oct;
        int unsigned             s;
        logic [DATA_WIDTH-1:0]   base;
        if (a == '0) return '0;
        t    = (2 ** ADDR_WIDTH - 1) - 32'(a);
        oct  = t / 12;
        s    = t % 12;
        case (s)
            0:       base = DATA_WIDTH'(21578);
            1:       base = DATA_WIDTH'(20367);
            2:       base = DATA_WIDTH'(19224);
            3:       base = DATA_WIDTH'(18145);
            4:       base = DATA_WIDTH'(17127);
            5:       base = DATA_WIDTH'(16165);
            6:       base = DATA_WIDTH'(15258);
            7:       base = DATA_WIDTH'(14402);
            8:       base = DATA_WIDTH'(13593);
            9:       base = DATA_WIDTH'(12830);
            10:      base = DATA_WIDTH'(12110);
            default: base = DATA_WIDTH'(11431);
        endcase
        return base >> oct;
    endfunction

    dffr #(.WIDTH(DATA_WIDTH)) step_ff (
        .clk   (clk),
        .reset (reset),
        .d     (lookup(addr)),
        .q     (data)
    );

endmodule

// File: rtl/note_player.sv
// Latches notes from the sequencer, counts beats, and drives the phase step.
// Optional macro NOTE_PLAYER_ARTICULATE_EN silences the last beat of every note.
module note_player #(
    parameter int unsigned NOTE_WIDTH = music_pkg::NOTE_WIDTH,
    parameter int unsigned DUR_WIDTH  = music_pkg::DUR_WIDTH,
    parameter int unsigned STEP_WIDTH = music_pkg::STEP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  beat,
    note_player_if.slave          seq,
    output logic [STEP_WIDTH-1:0] step_size,
    output logic                  busy
);

    import music_pkg::*;

    np_state_t             state;
    np_state_t             state_d;
    logic [2:0]            state_q;
    logic [DUR_WIDTH-1:0]  beats_left;
    logic [DUR_WIDTH-1:0]  beats_d;
    logic [NOTE_WIDTH-1:0] note_reg;
    logic [NOTE_WIDTH-1:0] rom_addr;
    logic [STEP_WIDTH-1:0] step_reg;
    logic                  mute;
    logic                  articulate_mute;

    assign state = np_state_t'(state_q);

    dffr #(.WIDTH(3), .RST_VAL(NP_IDLE)) state_ff (
        .clk   (clk),
        .reset (reset),
        .d     (state_d),
        .q     (state_q)
    );

    dffr #(.WIDTH(DUR_WIDTH)) beats_ff (
        .clk   (clk),
        .reset (reset),
        .d     (beats_d),
        .q     (beats_left)
    );

    dffre #(.WIDTH(NOTE_WIDTH)) note_ff (
        .clk   (clk),
        .reset (reset),
        .en    (seq.new_note),
        .d     (seq.note),
        .q     (note_reg)
    );

    // Reading entry 0 while idle lets a note started from IDLE show silence, not a stale step.
    assign rom_addr = (state == NP_IDLE) ? NOTE_WIDTH'(REST_NOTE) : note_reg;

    frequency_rom #(.ADDR_WIDTH(NOTE_WIDTH), .DATA_WIDTH(STEP_WIDTH)) rom (
        .clk   (clk),
        .reset (reset),
        .addr  (rom_addr),
        .data  (step_reg)
    );

    always_comb begin
        state_d = state;
        beats_d = beats_left;
        unique case (state)
            NP_IDLE: ;
            NP_PLAYING: begin
                if (play && beat) begin
                    if (beats_left <= DUR_WIDTH'(1)) state_d = NP_FINISHED;
                    else                             beats_d = beats_left - DUR_WIDTH'(1);
                end
            end
            NP_FINISHED: state_d = NP_IDLE;
            default:     state_d = NP_IDLE;
        endcase
        // A new note overrides any beat or finish decision in the same cycle.
        if (seq.new_note) begin
            state_d = NP_PLAYING;
            beats_d = (seq.duration == '0) ? DUR_WIDTH'(1) : seq.duration;
        end
    end

`ifdef NOTE_PLAYER_ARTICULATE_EN
    assign articulate_mute = (state == NP_PLAYING) && (beats_left == DUR_WIDTH'(1));
`else
    assign articulate_mute = 1'b0;
`endif

    assign mute          = (state == NP_IDLE) || !play ||
                           (note_reg == NOTE_WIDTH'(REST_NOTE)) || articulate_mute;
    assign step_size     = mute ? '0 : step_reg;
    assign busy          = (state == NP_PLAYING);
    assign seq.note_done = (state == NP_FINISHED);

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: vector table of notes plus hand-written corner sequences.
module tb_note_player;

    import music_pkg::*;

    logic        clk;
    logic        reset;
    logic        play;
    logic        beat;
    logic [19:0] step_size;
    logic        busy;

    note_player_if seq_if ();

    note_player dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .beat      (beat),
        .seq       (seq_if),
        .step_size (step_size),
        .busy      (busy)
    );

    typedef struct {
        logic [5:0]  note;
        logic [5:0]  dur;
        logic [19:0] step;
    } vec_t;

    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          sb[$];

    // Bench model of the note being played
    bit          active = 0;
    int          rem = 0;
    logic [19:0] cur_step = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int exp_c;
        if (seq_if.note_done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_note_done: got pulse at cycle %0d, expected none", cyc);
            end else begin
                exp_c = sb.pop_front();
                check("note_done_cycle", 32'(cyc), 32'(exp_c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [19:0] model_step();
        if (!active || !play) return '0;
`ifdef NOTE_PLAYER_ARTICULATE_EN
        if (rem == 1) return '0;
`endif
        return cur_step;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) begin
            tick();
            check("step_hold", 32'(step_size), 32'(model_step()));
            check("busy_hold", 32'(busy), 32'(active));
        end
    endtask

    task automatic start_note(input logic [5:0] n, input logic [5:0] d, input logic [19:0] st);
        int          eff;
        logic [19:0] exp1;
        eff  = (d == 0) ? 1 : int'(d);
        exp1 = (!active || n == 0 || !play) ? '0 : cur_step;
`ifdef NOTE_PLAYER_ARTICULATE_EN
        if (eff == 1) exp1 = '0;
`endif
        seq_if.new_note = 1'b1;
        seq_if.note     = n;
        seq_if.duration = d;
        tick();
        seq_if.new_note = 1'b0;
        beat            = 1'b0;
        active          = 1;
        rem             = eff;
        cur_step        = st;
        check("load_busy", 32'(busy), 32'd1);
        check("load_step_c1", 32'(step_size), 32'(exp1));
        tick();
        check("load_step_c2", 32'(step_size), 32'(model_step()));
    endtask

    task automatic do_beat();
        bit fin;
        fin  = active && play && (rem <= 1);
        beat = 1'b1;
        if (fin) sb.push_back(cyc + 1);
        tick();
        beat = 1'b0;
        if (active && play) rem--;
        if (fin) begin
            active = 0;
            check("finished_busy", 32'(busy), 32'd0);
            tick();
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_step", 32'(step_size), 32'd0);
        end else begin
            check("beat_step", 32'(step_size), 32'(model_step()));
            check("beat_busy", 32'(busy), 32'(active));
        end
    endtask

    task automatic play_beats(input int k, input int gap);
        repeat (k) begin
            idle_cycles(gap - 1);
            do_beat();
        end
    endtask

    initial begin
        vecs[0] = '{note: 6'd49, dur: 6'd3, step: 20'd9612};
        vecs[1] = '{note: 6'd49, dur: 6'd0, step: 20'd9612};
        vecs[2] = '{note: 6'd49, dur: 6'd1, step: 20'd9612};
        vecs[3] = '{note: 6'd0,  dur: 6'd2, step: 20'd0};
        vecs[4] = '{note: 6'd12, dur: 6'd2, step: 20'd1134};

        reset           = 1'b1;
        play            = 1'b0;
        beat            = 1'b0;
        seq_if.new_note = 1'b0;
        seq_if.note     = '0;
        seq_if.duration = '0;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step", 32'(step_size), 32'd0);
        check("rst_done", 32'(seq_if.note_done), 32'd0);
        check("rst_state", 32'(dut.state), 32'(NP_IDLE));
        reset = 1'b0;
        play  = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 5; i++) begin
            start_note(vecs[i].note, vecs[i].dur, vecs[i].step);
            play_beats(rem, 8);
            idle_cycles(3);
            check("sb_drain", 32'(sb.size()), 32'd0);
        end

        // Pause mid-note: beat coincides with play falling, another beat later in the window
        start_note(6'd49, 6'd4, 20'd9612);
        play_beats(2, 8);
        play = 1'b0;
        do_beat();
        idle_cycles(7);
        do_beat();
        idle_cycles(11);
        check("paused_beats_left", 32'(dut.beats_left), 32'd2);
        play = 1'b1;
        idle_cycles(2);
        play_beats(2, 8);
        idle_cycles(2);
        check("sb_drain_pause", 32'(sb.size()), 32'd0);

        // New note lands on the final beat of the previous one
        start_note(6'd49, 6'd2, 20'd9612);
        play_beats(1, 8);
        idle_cycles(7);
        beat = 1'b1;
        start_note(6'd12, 6'd4, 20'd1134);
        play_beats(4, 8);
        idle_cycles(2);
        check("sb_drain_coincide", 32'(sb.size()), 32'd0);

        // Reset at beat 2 of a 5-beat note
        start_note(6'd49, 6'd5, 20'd9612);
        play_beats(1, 8);
        idle_cycles(7);
        beat  = 1'b1;
        reset = 1'b1;
        tick();
        beat   = 1'b0;
        reset  = 1'b0;
        active = 0;
        rem    = 0;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_step", 32'(step_size), 32'd0);
        check("midrst_done", 32'(seq_if.note_done), 32'd0);
        check("midrst_state", 32'(dut.state), 32'(NP_IDLE));
        check("midrst_beats", 32'(dut.beats_left), 32'd0);
        play_beats(3, 8);
        idle_cycles(3);

        check("sb_final", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
